// File: rtl/spi_rx_frame_ctrl.sv
// SPI mode-0 receive-only slave with an Avalon-MM status/data window.
// Raw SPI pins are double-synchronized into clk; clk must run at least 4x sclk.
module spi_rx_frame_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  input  logic [1:0]        address,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              irq
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic              r_cs_s1, r_cs_s2;
  logic              r_mosi_s1, r_mosi_s2;
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_ovr_cnt;
  logic [CNT_W-1:0]  r_abort_cnt;
  logic [31:0]       r_readdata;

  logic              w_sclk_rise;
  logic              w_shift_en;
  logic              w_clr_bits;
  logic              w_frame_latch;
  logic              w_abort_evt;
  logic              w_ovr_evt;
  logic              w_rd0, w_rd1, w_rd2;
  logic [DATA_W-1:0] w_word;

  // NOTE: every clocked register uses non-blocking (<=) so all flops sample
  // pre-edge values; blocking here would turn the sync chain into a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_word      = {r_shift[DATA_W-2:0], r_mosi_s2};

  // NOTE: all outputs of this block get a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_en    = 1'b0;
    w_clr_bits    = 1'b0;
    w_frame_latch = 1'b0;
    w_abort_evt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_cs_s2) begin
          w_state_nxt = SHIFT;
          w_clr_bits  = 1'b1;
        end
      end
      SHIFT: begin
        if (r_cs_s2) begin
          w_state_nxt = IDLE;
          w_abort_evt = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_frame_latch = 1'b1;
            w_state_nxt   = HOLD;
          end
        end
      end
      HOLD: begin
        if (r_cs_s2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_bits) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= w_word;
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
    end
  end

  assign w_rd0 = read && (address == 2'd0);
  assign w_rd1 = read && (address == 2'd1);
  assign w_rd2 = read && (address == 2'd2);

  // A same-cycle data read hands the old word to the host, so it is not an overrun.
  assign w_ovr_evt = w_frame_latch & r_rx_valid & ~w_rd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_ovr_cnt   <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_frame_latch) r_rx_data <= w_word;

      if (w_frame_latch)   r_rx_valid <= 1'b1;
      else if (w_rd0)      r_rx_valid <= 1'b0;

      if (w_ovr_evt)       r_overrun <= 1'b1;
      else if (w_rd1)      r_overrun <= 1'b0;

      if (w_rd2)
        r_ovr_cnt <= w_ovr_evt ? CNT_W'(1) : '0;
      else if (w_ovr_evt && (r_ovr_cnt != '1))
        r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);

      if (w_rd2)
        r_abort_cnt <= w_abort_evt ? CNT_W'(1) : '0;
      else if (w_abort_evt && (r_abort_cnt != '1))
        r_abort_cnt <= r_abort_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (read) begin
      case (address)
        2'd0:    r_readdata <= 32'(r_rx_data);
        2'd1:    r_readdata <= 32'({r_ovr_cnt, r_abort_cnt, r_state, r_overrun, r_rx_valid});
        2'd2:    r_readdata <= 32'({r_ovr_cnt, r_abort_cnt, 4'b0000});
        default: r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign irq      = r_rx_valid | r_overrun;

endmodule
